inst_buffer: RTL
================

Name: inst_buffer

Overview:
- Instruction buffer that sits directly downstream of the predecode stage.
- Accepts up to BLOCK_INST_SIZE compacted instructions per cycle into a circular queue.
- Presents up to DECODE_WIDTH oldest instructions per cycle to decode.
- Drives the ibuf_full back-pressure that stalls predecode and the cache pipe; flushes on backend/predecode redirect.

Parameters:
BLOCK_INST_SIZE, 8, max instructions enqueued per cycle
DECODE_WIDTH, 4, max instructions dequeued per cycle
DEPTH, 32, queue entries (power of 2, >= 2*BLOCK_INST_SIZE)
FSQ_WIDTH, 4, fetch-stream-queue index width
OFFSET_WIDTH, 4, per-instruction offset-in-block width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_en  in  BLOCK_INST_SIZE  valid mask of compacted slots; prefix-contiguous from bit 0
in_num  in  $clog2(BLOCK_INST_SIZE)+1  number of valid slots (authoritative)
in_inst  in  BLOCK_INST_SIZE*32  instruction words, slot i at [32i+:32]
in_offset  in  BLOCK_INST_SIZE*OFFSET_WIDTH  offset of slot i within its fetch block
in_fsq_idx  in  FSQ_WIDTH  stream index shared by all slots
in_iam  in  1  instruction-address-misaligned; applies to slot 0 only
in_ipf  in  1  instruction page fault; applies to every valid slot
flush  in  1  redirect (backend or predecode); empties queue
full  out  1  free entries < BLOCK_INST_SIZE
out_valid  out  DECODE_WIDTH  slot valid, prefix-contiguous
out_inst  out  DECODE_WIDTH*32  instructions, oldest in slot 0
out_offset  out  DECODE_WIDTH*OFFSET_WIDTH  offsets
out_fsq_idx  out  DECODE_WIDTH*FSQ_WIDTH  stream index per slot
out_exc  out  DECODE_WIDTH*2  {ipf, iam} per slot
out_ready  in  1  decode accepts every presented valid slot this cycle

Behaviour:
- State: head and tail pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits. Entry storage holds {inst, offset, fsq_idx, ipf, iam}.
- Reset (sync, rst=1 at posedge): head=tail=count=0; full=0; out_valid=0. Storage contents are don't-care.
- full: combinational from count. full = (DEPTH-count) < BLOCK_INST_SIZE. Predecode holds its data while full=1.
- Enqueue: enq = in_en[0] & ~full & ~flush; enq_n = enq ? in_num : 0.
  - Slot i < in_num is written to entry (tail+i) mod DEPTH.
  - iam is stored only for slot 0. ipf is stored for all written slots.
  - tail += enq_n.
  - in_en and in_num must agree; in_num governs the write.
- Dequeue:
  - out_valid[i] = (i < count), taken combinationally from storage at (head+i) mod DEPTH.
  - deq_n = out_ready ? popcount(out_valid) : 0; head += deq_n.
  - Partial acceptance is not supported.
- Count update: count_next = count + enq_n - deq_n in the same cycle. Simultaneous enqueue and dequeue are legal at any occupancy, including when full=1 (dequeue still proceeds).
- Latency: an enqueued instruction is visible on out_* the cycle after the write edge (1 cycle), unless the bypass option applies.
- Flush has highest priority: head=tail=count=0 next cycle. Enqueue and dequeue in the flush cycle are discarded. out_valid=0 the cycle after flush.
- Wrap: a 3-slot write with tail=DEPTH-1 writes entries 31, 0, 1 (DEPTH=32). Reads wrap identically.
- Empty: out_valid=0 and out_ready is ignored.
- count never exceeds DEPTH; guaranteed by the full threshold.
- rst asserted mid-operation behaves exactly as flush and additionally clears full.

Optional Feature:
Macro IBUF_BYPASS_EN.
- Defined: when count==0, flush==0 and enq==1, out_* is driven combinationally from in_* slots 0..min(in_num,DECODE_WIDTH)-1.
  - If out_ready=1, those slots are consumed: only the remaining in_num-deq_n slots are written, starting at tail; count += in_num-deq_n; head=tail advance accordingly.
  - If out_ready=0, all slots are written normally.
  - Gives 0-cycle latency through an empty buffer.
- Undefined: no input-to-output combinational path; latency is always 1 cycle.

Test Plan:
1. Reset, then enqueue in_num=5, fsq=3 with out_ready=0 -> next cycle out_valid=4'b1111, out_inst = slots 0..3, out_fsq_idx=3, count=5, full=0.
2. Fill to count=25 with out_ready=0 -> full=1, and a further enqueue is ignored. Then out_ready=1 for 1 cycle -> count=21, full=0 (21 <= 24).
3. Enqueue 8 and dequeue 4 in the same cycle at count=10 -> count=14, head advances 4, tail advances 8.
4. Set tail=head=30 (empty), enqueue 4 -> entries 30, 31, 0, 1 written; output order preserved across the wrap.
5. flush together with enq=8 and out_ready=1 at count=12 -> next cycle count=0, out_valid=0, full=0; no enqueued data appears.
6. Enqueue with in_iam=1, in_ipf=1, in_num=3 -> out_exc slot0={1,1}, slots 1-2={1,0}. With IBUF_BYPASS_EN defined, an empty buffer shows these same-cycle.

Source files
------------

// File: rtl/inst_buffer.sv
// inst_buffer
//   Circular instruction queue between predecode and decode. Accepts up to
//   BLOCK_INST_SIZE compacted instructions per cycle. Presents up to
//   DECODE_WIDTH oldest instructions per cycle. Raises full back-pressure
//   when fewer than BLOCK_INST_SIZE entries are free. Flush or rst empties
//   the queue.
//
//   Optional build macro IBUF_BYPASS_EN: when the queue is empty, incoming
//   slots are presented to decode in the same cycle (0-cycle latency).
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_en, in_num   enqueue slot mask / count (in_num is authoritative)
//   in_inst         instruction words, slot i at [32i+:32]
//   in_offset       per-slot offset within the fetch block
//   in_fsq_idx      fetch-stream-queue index shared by all slots
//   in_iam, in_ipf  misaligned (slot 0 only) / page fault (all slots)
//   flush           redirect; empties the queue
//   full            back-pressure to predecode
//   out_valid       prefix-contiguous slot valids, oldest in slot 0
//   out_inst, out_offset, out_fsq_idx, out_exc ({ipf, iam})
//   out_ready       decode takes every presented valid slot
module inst_buffer #(
   parameter int BLOCK_INST_SIZE = 8,
   parameter int DECODE_WIDTH    = 4,
   parameter int DEPTH           = 32,
   parameter int FSQ_WIDTH       = 4,
   parameter int OFFSET_WIDTH    = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [BLOCK_INST_SIZE-1:0]           in_en,
   input  logic [$clog2(BLOCK_INST_SIZE):0]     in_num,
   input  logic [BLOCK_INST_SIZE*32-1:0]        in_inst,
   input  logic [BLOCK_INST_SIZE*OFFSET_WIDTH-1:0] in_offset,
   input  logic [FSQ_WIDTH-1:0]                 in_fsq_idx,
   input  logic                                 in_iam,
   input  logic                                 in_ipf,
   input  logic                                 flush,
   output logic                                 full,
   output logic [DECODE_WIDTH-1:0]              out_valid,
   output logic [DECODE_WIDTH*32-1:0]           out_inst,
   output logic [DECODE_WIDTH*OFFSET_WIDTH-1:0] out_offset,
   output logic [DECODE_WIDTH*FSQ_WIDTH-1:0]    out_fsq_idx,
   output logic [DECODE_WIDTH*2-1:0]            out_exc,
   input  logic                                 out_ready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = $clog2(BLOCK_INST_SIZE) + 1;

   logic [31:0]           inst_q [DEPTH];
   logic [OFFSET_WIDTH-1:0] off_q [DEPTH];
   logic [FSQ_WIDTH-1:0]  fsq_q  [DEPTH];
   logic                  ipf_q  [DEPTH];
   logic                  iam_q  [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] free_n;
   logic          enq;
   logic [NW-1:0] enq_n;
   logic [CW-1:0] deq_n;
   logic          bypass;

   always_comb begin
      free_n = CW'(DEPTH) - count;
      full   = free_n < CW'(BLOCK_INST_SIZE);
      enq    = in_en[0] & ~full & ~flush;
      enq_n  = enq ? in_num : '0;
   end

`ifdef IBUF_BYPASS_EN
   assign bypass = (count == '0) && enq;
`else
   assign bypass = 1'b0;
`endif

   for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_out
      logic [PW-1:0] ridx;
      assign ridx = head + PW'(g);

      assign out_valid[g] = bypass ? (NW'(g) < in_num) : (CW'(g) < count);
      assign out_inst[32*g +: 32] = bypass ? in_inst[32*g +: 32] : inst_q[ridx];
      assign out_offset[OFFSET_WIDTH*g +: OFFSET_WIDTH] =
         bypass ? in_offset[OFFSET_WIDTH*g +: OFFSET_WIDTH] : off_q[ridx];
      assign out_fsq_idx[FSQ_WIDTH*g +: FSQ_WIDTH] = bypass ? in_fsq_idx : fsq_q[ridx];
      assign out_exc[2*g +: 2] = bypass ? {in_ipf, (g == 0) ? in_iam : 1'b0}
                                        : {ipf_q[ridx], iam_q[ridx]};
   end

   always_comb begin
      deq_n = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         deq_n = deq_n + CW'(out_valid[i]);
      end
      if (!out_ready) begin
         deq_n = '0;
      end
   end

   // Every accepted slot is written at tail+i, including slots consumed by
   // the bypass path; head then skips over the consumed ones, so only the
   // unconsumed remainder is ever presented again.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
         if (enq && (NW'(i) < in_num)) begin
            inst_q[tail + PW'(i)] <= in_inst[32*i +: 32];
            off_q[tail + PW'(i)]  <= in_offset[OFFSET_WIDTH*i +: OFFSET_WIDTH];
            fsq_q[tail + PW'(i)]  <= in_fsq_idx;
            ipf_q[tail + PW'(i)]  <= in_ipf;
            iam_q[tail + PW'(i)]  <= (i == 0) ? in_iam : 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_n);
         tail  <= tail + PW'(enq_n);
         count <= count + CW'(enq_n) - deq_n;
      end
   end

endmodule
